// File: rtl/cv32e40p_tmr_voter_if.sv
// Replica-side and EX-side handshake bundle for the TMR result voter.
// The slave modport is the voter; master drives the replica/EX side.
interface cv32e40p_tmr_voter_if;
  logic        issue_i;
  logic [31:0] result_1_i;
  logic [31:0] result_2_i;
  logic [31:0] result_3_i;
  logic        comparison_result_1_i;
  logic        comparison_result_2_i;
  logic        comparison_result_3_i;
  logic        ready_1_i;
  logic        ready_2_i;
  logic        ready_3_i;
  logic        ex_ready_i;
  logic [31:0] result_o;
  logic        comparison_result_o;
  logic        ready_o;

  modport master (
    output issue_i,
    output result_1_i, result_2_i, result_3_i,
    output comparison_result_1_i, comparison_result_2_i, comparison_result_3_i,
    output ready_1_i, ready_2_i, ready_3_i,
    output ex_ready_i,
    input  result_o, comparison_result_o, ready_o
  );

  modport slave (
    input  issue_i,
    input  result_1_i, result_2_i, result_3_i,
    input  comparison_result_1_i, comparison_result_2_i, comparison_result_3_i,
    input  ready_1_i, ready_2_i, ready_3_i,
    input  ex_ready_i,
    output result_o, comparison_result_o, ready_o
  );
endinterface

// File: rtl/cv32e40p_tmr_voter.sv
// Majority voter for the triplicated ALU/multiplier: collects skewed replica
// results, votes on {result, comparison}, and tracks sticky per-replica faults.
module cv32e40p_tmr_voter #(
  parameter int unsigned SKEW_MAX  = 4,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cv32e40p_tmr_voter_if.slave    bus,
  input  logic                   clear_i,
  output logic [2:0]             fault_o,
  output logic [3*ERR_CNT_W-1:0] err_cnt_o,
  output logic                   uncorrectable_o,
  output logic                   fatal_o
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_e;

  state_e               state_q, state_d;
  logic [2:0]           arrived_q;
  logic [3:0]           skew_q;
  logic [32:0]          word_q [3];
  logic [32:0]          vote_q;
  logic                 unc_q;
  logic [2:0]           fault_q;
  logic                 fatal_q;
  logic [ERR_CNT_W-1:0] cnt_q [3];

  logic [32:0] w_in  [3];
  logic [32:0] w_eff [3];
  logic [2:0]  rdy_in;
  logic        collecting, new_op;
  logic [2:0]  arr_base, capture, arr_eff;
  logic [3:0]  skew_base;
  logic        timeout, fire;
  logic [32:0] maj, voted;
  logic [2:0]  ev_fault;
  logic        ev_unc;

  assign w_in[0] = {bus.result_1_i, bus.comparison_result_1_i};
  assign w_in[1] = {bus.result_2_i, bus.comparison_result_2_i};
  assign w_in[2] = {bus.result_3_i, bus.comparison_result_3_i};
  assign rdy_in  = {bus.ready_3_i, bus.ready_2_i, bus.ready_1_i};

  // The issue cycle (from IDLE, or back-to-back out of HOLD) behaves as a
  // collect cycle with cleared arrival state, so same-cycle ready is captured.
  always_comb begin
    collecting = (state_q == S_COLLECT) ||
                 (bus.issue_i && ((state_q == S_IDLE) ||
                                  ((state_q == S_HOLD) && bus.ex_ready_i)));
    new_op     = collecting && (state_q != S_COLLECT);
    arr_base   = new_op ? '0 : arrived_q;
    capture    = collecting ? (rdy_in & ~arr_base) : '0;
    arr_eff    = arr_base | capture;
    skew_base  = new_op ? '0 : skew_q;
    timeout    = (skew_base == 4'(SKEW_MAX));
    fire       = collecting && ((&arr_eff) || timeout);
  end

  always_comb begin
    for (int unsigned k = 0; k < 3; k++) begin
      w_eff[k] = capture[k] ? w_in[k] : word_q[k];
    end
  end

  // Missing replicas and any arrived replica differing from the output are
  // faulty; two or more faulty replicas means no usable majority existed.
  always_comb begin
    maj = (w_eff[0] & w_eff[1]) | (w_eff[0] & w_eff[2]) | (w_eff[1] & w_eff[2]);
    if (&arr_eff)       voted = maj;
    else if (arr_eff[0]) voted = w_eff[0];
    else if (arr_eff[1]) voted = w_eff[1];
    else                 voted = w_eff[2];
    ev_fault = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      ev_fault[k] = fire && (!arr_eff[k] || (w_eff[k] != voted));
    end
    ev_unc = fire && ($countones(ev_fault) >= 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (collecting)                              state_d = fire ? S_HOLD : S_COLLECT;
    else if ((state_q == S_HOLD) && bus.ex_ready_i) state_d = S_IDLE;
  end

  always_comb begin
    bus.ready_o             = (state_q == S_HOLD);
    bus.result_o            = vote_q[32:1];
    bus.comparison_result_o = vote_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arrived_q <= '0;
      skew_q    <= '0;
      for (int unsigned k = 0; k < 3; k++) word_q[k] <= '0;
    end else if (collecting) begin
      arrived_q <= arr_eff;
      skew_q    <= (|arr_eff) ? skew_base + 4'd1 : skew_base;
      for (int unsigned k = 0; k < 3; k++) word_q[k] <= w_eff[k];
    end else if ((state_q == S_HOLD) && bus.ex_ready_i) begin
      arrived_q <= '0;
      skew_q    <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_q <= '0;
      unc_q  <= 1'b0;
    end else begin
      unc_q <= ev_unc;
      if (fire) vote_q <= voted;
    end
  end

  // A fault event coinciding with clear_i survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= '0;
      fatal_q <= 1'b0;
      for (int unsigned k = 0; k < 3; k++) cnt_q[k] <= '0;
    end else if (clear_i) begin
      fault_q <= ev_fault;
      fatal_q <= ev_unc;
      for (int unsigned k = 0; k < 3; k++) begin
        cnt_q[k] <= ev_fault[k] ? ERR_CNT_W'(1) : '0;
      end
    end else begin
      fault_q <= fault_q | ev_fault;
      fatal_q <= fatal_q | ev_unc;
      for (int unsigned k = 0; k < 3; k++) begin
        if (ev_fault[k] && (cnt_q[k] != '1)) cnt_q[k] <= cnt_q[k] + ERR_CNT_W'(1);
      end
    end
  end

  always_comb begin
    err_cnt_o = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      err_cnt_o[k*ERR_CNT_W +: ERR_CNT_W] = cnt_q[k];
    end
    fault_o         = fault_q;
    fatal_o         = fatal_q;
    uncorrectable_o = unc_q;
  end

endmodule
